// File: rtl/me_best_mv_tracker_if.sv
// -----------------------------------------------------------------------------
// me_best_mv_tracker_if
// SAD vector handshake between the SAD adder tree (master) and the best
// motion-vector tracker (slave).
//   sad_valid : master -> slave, sad_in holds the SAD vector for the current
//               search position
//   sad_ready : slave -> master, tracker accepts a vector this cycle
//   sad_in    : master -> slave, channel k at bits [k*SAD_W +: SAD_W]
// A transfer happens on a rising clock edge where sad_valid && sad_ready.
// -----------------------------------------------------------------------------
interface me_best_mv_tracker_if #(
  parameter int NUM_PART = 4,
  parameter int SAD_W    = 16
);

  logic                      sad_valid;
  logic                      sad_ready;
  logic [NUM_PART*SAD_W-1:0] sad_in;

  // The SAD tree drives data and valid, and watches ready
  modport master (
    output sad_valid,
    output sad_in,
    input  sad_ready
  );

  // The tracker consumes data and valid, and drives ready
  modport slave (
    input  sad_valid,
    input  sad_in,
    output sad_ready
  );

endinterface

// File: rtl/me_best_mv_tracker.sv
// -----------------------------------------------------------------------------
// me_best_mv_tracker
// Tracks the minimum SAD and its signed, centred motion vector for NUM_PART
// partition channels in parallel (channel 0 = whole macroblock) while the
// search-position raster is generated internally. Supports optional early
// termination on channel 0.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous reset, active high
//   i_start      begin a new search (only looked at in IDLE)
//   i_early_en   enable early termination, latched at start
//   i_early_thr  early-termination threshold, latched at start
//   sadBus       SAD vector handshake (slave side)
//   o_busy       search in progress
//   o_done       one-cycle pulse, results valid
//   o_early_hit  last search ended early, held until the next start
//   o_best_sad   per-channel minimum SAD
//   o_best_mv_x  per-channel signed x component of the best MV
//   o_best_mv_y  per-channel signed y component of the best MV
// -----------------------------------------------------------------------------
module me_best_mv_tracker #(
  parameter int NUM_PART     = 4,
  parameter int SAD_W        = 16,
  parameter int SEARCH_RANGE = 33,
  parameter int MV_W         = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_early_en,
  input  logic [SAD_W-1:0]          i_early_thr,
  me_best_mv_tracker_if.slave       sadBus,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_early_hit,
  output logic [NUM_PART*SAD_W-1:0] o_best_sad,
  output logic [NUM_PART*MV_W-1:0]  o_best_mv_x,
  output logic [NUM_PART*MV_W-1:0]  o_best_mv_y
);

  localparam int               POS_W    = $clog2(SEARCH_RANGE);
  localparam int               CENTER   = (SEARCH_RANGE - 1) / 2;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(SEARCH_RANGE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                    r_state;
  logic [POS_W-1:0]          r_posX;
  logic [POS_W-1:0]          r_posY;
  logic                      r_earlyEn;
  logic [SAD_W-1:0]          r_earlyThr;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_earlyHit;
  logic                      r_sadReady;
  logic [NUM_PART*SAD_W-1:0] r_bestSad;
  logic [NUM_PART*MV_W-1:0]  r_bestMvX;
  logic [NUM_PART*MV_W-1:0]  r_bestMvY;

  logic                      w_fire;
  logic                      w_lastPos;
  logic                      w_earlyStop;
  logic [NUM_PART-1:0]       w_improve;
  logic [MV_W-1:0]           w_mvX;
  logic [MV_W-1:0]           w_mvY;

  // Raster position minus the centre, wrapped into MV_W-bit two's complement.
  // The position is unsigned, so it is zero-extended before the subtraction.
  function automatic logic [MV_W-1:0] toMv(input logic [POS_W-1:0] pos);
    logic signed [31:0] diff;
    diff = 32'(pos) - CENTER;
    return diff[MV_W-1:0];
  endfunction

  // Handshake and termination conditions for the current cycle. Early
  // termination only ever looks at channel 0 (whole macroblock) against the
  // threshold captured when the search started.
  always_comb begin
    w_fire      = sadBus.sad_valid && r_sadReady;
    w_lastPos   = (r_posX == LAST_POS) && (r_posY == LAST_POS);
    w_earlyStop = r_earlyEn && (sadBus.sad_in[SAD_W-1:0] < r_earlyThr);
    w_mvX       = toMv(r_posX);
    w_mvY       = toMv(r_posY);
  end

  // Strict unsigned compare per channel, so on a tie the earlier raster
  // position keeps the slot.
  always_comb begin
    w_improve = '0;
    for (int k = 0; k < NUM_PART; k++) begin
      w_improve[k] = sadBus.sad_in[k*SAD_W +: SAD_W] < r_bestSad[k*SAD_W +: SAD_W];
    end
  end

  // Search FSM with all outputs registered. IDLE waits for start and
  // initialises the search; RUN consumes one SAD vector per transfer, updates
  // every channel and walks the raster (x fastest); DONE raises done for a
  // single cycle. Results and early_hit are only touched by a new start or a
  // transfer, so they hold from DONE until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_posX     <= '0;
      r_posY     <= '0;
      r_earlyEn  <= 1'b0;
      r_earlyThr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_earlyHit <= 1'b0;
      r_sadReady <= 1'b0;
      r_bestSad  <= '1;
      r_bestMvX  <= '0;
      r_bestMvY  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_sadReady <= 1'b1;
            r_posX     <= '0;
            r_posY     <= '0;
            r_earlyEn  <= i_early_en;
            r_earlyThr <= i_early_thr;
            r_earlyHit <= 1'b0;
            r_bestSad  <= '1;
            r_bestMvX  <= '0;
            r_bestMvY  <= '0;
          end
        end

        RUN: begin
          if (w_fire) begin
            for (int k = 0; k < NUM_PART; k++) begin
              if (w_improve[k]) begin
                r_bestSad[k*SAD_W +: SAD_W] <= sadBus.sad_in[k*SAD_W +: SAD_W];
                r_bestMvX[k*MV_W +: MV_W]   <= w_mvX;
                r_bestMvY[k*MV_W +: MV_W]   <= w_mvY;
              end
            end
            // The terminating transfer still updates the channels above
            if (w_lastPos || w_earlyStop) begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_sadReady <= 1'b0;
              r_done     <= 1'b1;
              r_earlyHit <= w_earlyStop;
            end else if (r_posX == LAST_POS) begin
              r_posX <= '0;
              r_posY <= r_posY + 1'b1;
            end else begin
              r_posX <= r_posX + 1'b1;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_sadReady <= 1'b0;
        end
      endcase
    end
  end

  assign sadBus.sad_ready = r_sadReady;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_early_hit      = r_earlyHit;
  assign o_best_sad       = r_bestSad;
  assign o_best_mv_x      = r_bestMvX;
  assign o_best_mv_y      = r_bestMvY;

endmodule

// File: tb/tb_me_best_mv_tracker.sv
// -----------------------------------------------------------------------------
// tb_me_best_mv_tracker
// Directed self-checking bench for me_best_mv_tracker with default parameters
// (4 channels, 16-bit SAD, 33x33 search, 6-bit MVs). Expected values are
// hand-computed from raster indices: index i sits at (i % 33, i / 33) and the
// MV is that position minus 16.
// -----------------------------------------------------------------------------
module tb_me_best_mv_tracker;

  localparam int NUM_PART     = 4;
  localparam int SAD_W        = 16;
  localparam int SEARCH_RANGE = 33;
  localparam int MV_W         = 6;
  localparam int TOTAL        = SEARCH_RANGE * SEARCH_RANGE;
  localparam int BUDGET       = 4000;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic                      earlyEn = 1'b0;
  logic [SAD_W-1:0]          earlyThr = '0;
  logic                      busy;
  logic                      done;
  logic                      earlyHit;
  logic [NUM_PART*SAD_W-1:0] bestSad;
  logic [NUM_PART*MV_W-1:0]  bestMvX;
  logic [NUM_PART*MV_W-1:0]  bestMvY;

  int errCount   = 0;
  int checkCount = 0;

  me_best_mv_tracker_if #(.NUM_PART(NUM_PART), .SAD_W(SAD_W)) sadBus ();

  me_best_mv_tracker #(
    .NUM_PART    (NUM_PART),
    .SAD_W       (SAD_W),
    .SEARCH_RANGE(SEARCH_RANGE),
    .MV_W        (MV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_early_en (earlyEn),
    .i_early_thr(earlyThr),
    .sadBus     (sadBus),
    .o_busy     (busy),
    .o_done     (done),
    .o_early_hit(earlyHit),
    .o_best_sad (bestSad),
    .o_best_mv_x(bestMvX),
    .o_best_mv_y(bestMvY)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single point of comparison: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compares one channel's SAD and signed MV against expected integers
  task automatic checkChannel(input string tag, input int k, input int eSad,
                              input int eMx, input int eMy);
    logic [MV_W-1:0] ex;
    logic [MV_W-1:0] ey;
    ex = eMx[MV_W-1:0];
    ey = eMy[MV_W-1:0];
    checkOutput($sformatf("%s_sad%0d", tag, k), 64'(bestSad[k*SAD_W +: SAD_W]), 64'(eSad));
    checkOutput($sformatf("%s_mvx%0d", tag, k), 64'(bestMvX[k*MV_W +: MV_W]), 64'(ex));
    checkOutput($sformatf("%s_mvy%0d", tag, k), 64'(bestMvY[k*MV_W +: MV_W]), 64'(ey));
  endtask

  // SAD vector for raster index idx under each stimulus pattern
  function automatic logic [NUM_PART*SAD_W-1:0] sadFor(input int mode, input int idx);
    logic [NUM_PART*SAD_W-1:0] v;
    for (int k = 0; k < NUM_PART; k++) v[k*SAD_W +: SAD_W] = SAD_W'(1000);
    case (mode)
      0: if (idx == 5*SEARCH_RANGE + 20) v[SAD_W-1:0] = SAD_W'(10);
      1: for (int k = 0; k < NUM_PART; k++) v[k*SAD_W +: SAD_W] = SAD_W'(2000 - idx);
      2: if (idx == 100) v[SAD_W-1:0] = SAD_W'(40);
      3: if (idx == 3 || idx == 700)
           for (int k = 0; k < NUM_PART; k++) v[k*SAD_W +: SAD_W] = SAD_W'(7);
      default: ;
    endcase
    return v;
  endfunction

  // Starts a search and feeds it until done, the edge budget, or abortAt
  // transfers. Called and returns 1 time unit after a rising edge. edges
  // counts rising edges from the start edge (inclusive) up to the edge after
  // which done is first seen.
  task automatic applyStimulus(input int mode, input int gapPct, input int abortAt,
                               input bit startNoise, output int nXfer,
                               output int edges, output bit sawDone);
    bit v;
    bit fire;
    nXfer   = 0;
    sawDone = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    checkOutput("busyAfterStart", 64'(busy), 64'd1);
    checkOutput("readyAfterStart", 64'(sadBus.sad_ready), 64'd1);
    while (!sawDone && edges < BUDGET && !(abortAt >= 0 && nXfer >= abortAt)) begin
      v = ($urandom_range(99) >= gapPct);
      sadBus.sad_valid = v;
      sadBus.sad_in    = sadFor(mode, nXfer);
      if (startNoise) start = 1'($urandom_range(1));
      fire = v && sadBus.sad_ready;
      @(posedge clk);
      #1;
      edges++;
      if (fire) nXfer++;
      sawDone = done;
    end
    sadBus.sad_valid = 1'b0;
    start            = 1'b0;
  endtask

  // Bus and control outputs at their reset values
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_ready"}, 64'(sadBus.sad_ready), 64'd0);
    checkOutput({tag, "_earlyHit"}, 64'(earlyHit), 64'd0);
    checkOutput({tag, "_bestSad"}, 64'(bestSad), {64{1'b1}});
    checkOutput({tag, "_mvx"}, 64'(bestMvX), 64'd0);
    checkOutput({tag, "_mvy"}, 64'(bestMvY), 64'd0);
  endtask

  // Results of a full search with the single minimum at (20,5) on channel 0
  task automatic checkSpikeResult(input string tag);
    checkChannel(tag, 0, 10, 4, -11);
    for (int k = 1; k < NUM_PART; k++) checkChannel(tag, k, 1000, -16, -16);
    checkOutput({tag, "_earlyHit"}, 64'(earlyHit), 64'd0);
  endtask

  initial begin
    int  nXfer;
    int  edges;
    bit  sawDone;

    sadBus.sad_valid = 1'b0;
    sadBus.sad_in    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full search, single spike on channel 0
    applyStimulus(0, 0, -1, 1'b0, nXfer, edges, sawDone);
    checkOutput("full_done", 64'(sawDone), 64'd1);
    checkOutput("full_xfers", 64'(nXfer), 64'(TOTAL));
    checkOutput("full_edges", 64'(edges), 64'(TOTAL + 1));
    checkOutput("full_busyAtDone", 64'(busy), 64'd0);
    checkSpikeResult("full");
    @(posedge clk);
    #1;
    checkOutput("full_donePulse", 64'(done), 64'd0);

    // Descending ramp: last position wins everywhere
    applyStimulus(1, 0, -1, 1'b0, nXfer, edges, sawDone);
    checkOutput("ramp_done", 64'(sawDone), 64'd1);
    for (int k = 0; k < NUM_PART; k++) checkChannel("ramp", k, 2000 - (TOTAL - 1), 16, 16);
    @(posedge clk);
    #1;

    // Early termination at transfer index 100
    earlyEn  = 1'b1;
    earlyThr = SAD_W'(50);
    applyStimulus(2, 0, -1, 1'b0, nXfer, edges, sawDone);
    earlyEn  = 1'b0;
    earlyThr = '0;
    checkOutput("early_done", 64'(sawDone), 64'd1);
    checkOutput("early_xfers", 64'(nXfer), 64'd101);
    checkOutput("early_hit", 64'(earlyHit), 64'd1);
    checkChannel("early", 0, 40, -15, -13);
    checkChannel("early", 1, 1000, -16, -16);
    @(posedge clk);
    #1;
    checkOutput("early_hitHeld", 64'(earlyHit), 64'd1);
    checkChannel("earlyHeld", 0, 40, -15, -13);

    // Same spike search with roughly half the cycles idle
    applyStimulus(0, 50, -1, 1'b0, nXfer, edges, sawDone);
    checkOutput("gaps_done", 64'(sawDone), 64'd1);
    checkOutput("gaps_xfers", 64'(nXfer), 64'(TOTAL));
    checkSpikeResult("gaps");
    @(posedge clk);
    #1;

    // Reset mid-search after 500 transfers, then a clean search
    applyStimulus(1, 0, 500, 1'b0, nXfer, edges, sawDone);
    checkOutput("abort_xfers", 64'(nXfer), 64'd500);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("abort");
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_noDone", 64'(done), 64'd0);
    checkOutput("abort_idle", 64'(busy), 64'd0);
    applyStimulus(0, 0, -1, 1'b0, nXfer, edges, sawDone);
    checkOutput("rerun_done", 64'(sawDone), 64'd1);
    checkOutput("rerun_xfers", 64'(nXfer), 64'(TOTAL));
    checkSpikeResult("rerun");
    @(posedge clk);
    #1;

    // Equal minima at indices 3 and 700 with start toggling during RUN
    applyStimulus(3, 0, -1, 1'b1, nXfer, edges, sawDone);
    checkOutput("tie_done", 64'(sawDone), 64'd1);
    checkOutput("tie_xfers", 64'(nXfer), 64'(TOTAL));
    for (int k = 0; k < NUM_PART; k++) checkChannel("tie", k, 7, -13, -16);

    // start held during the DONE cycle must not launch a search
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("startInDone_busy", 64'(busy), 64'd0);
    checkOutput("startInDone_done", 64'(done), 64'd0);
    checkOutput("startInDone_ready", 64'(sadBus.sad_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("startInDone_stillIdle", 64'(busy), 64'd0);
    checkChannel("tieHeld", 0, 7, -13, -16);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
